// File: rtl/snake_event_gen.sv
// Snake game core: advances the body one cell per step and emits apple_eaten/collision one cycle after the step.
// No backpressure: a step arriving during apple placement is held (one deep) and replayed on the first RUN cycle.
module snake_event_gen #(
  parameter  int GRID_W  = 16,
  parameter  int GRID_H  = 12,
  parameter  int MAX_LEN = 32,
  localparam int X_W     = $clog2(GRID_W),
  localparam int Y_W     = $clog2(GRID_H),
  localparam int L_W     = $clog2(MAX_LEN + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           step,
  input  logic [1:0]     dir_in,
  output logic           apple_eaten,
  output logic           collision,
  output logic [X_W-1:0] head_x,
  output logic [Y_W-1:0] head_y,
  output logic [X_W-1:0] apple_x,
  output logic [Y_W-1:0] apple_y,
  output logic [L_W-1:0] length,
  output logic           alive
);
  localparam int I_W = $clog2(MAX_LEN);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PLACE, S_DEAD} state_t;

  state_t         r_state, w_state_nxt;
  logic [X_W-1:0] r_seg_x [MAX_LEN];
  logic [Y_W-1:0] r_seg_y [MAX_LEN];
  logic [L_W-1:0] r_len, r_idx, w_lim;
  logic [1:0]     r_dir, w_dir;
  logic [X_W-1:0] r_apple_x, r_cand_x, w_nx;
  logic [Y_W-1:0] r_apple_y, r_cand_y, w_ny;
  logic [7:0]     r_lfsr;
  logic           r_pend, r_eaten, r_coll;
  logic           w_fb, w_do_step, w_wall, w_self, w_eat, w_coll;
  logic           w_cand_bad, w_scan_done, w_scan_hit;

  assign w_fb      = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_do_step = (r_state == S_RUN) && (step || r_pend);
  assign w_dir     = (dir_in == (r_dir ^ 2'd2)) ? r_dir : dir_in;

  always_comb begin
    w_nx   = r_seg_x[0];
    w_ny   = r_seg_y[0];
    w_wall = 1'b0;
    case (w_dir)
      2'd0: begin w_wall = (r_seg_x[0] == X_W'(GRID_W - 1)); w_nx = r_seg_x[0] + X_W'(1); end
      2'd1: begin w_wall = (r_seg_y[0] == Y_W'(GRID_H - 1)); w_ny = r_seg_y[0] + Y_W'(1); end
      2'd2: begin w_wall = (r_seg_x[0] == '0);               w_nx = r_seg_x[0] - X_W'(1); end
      default: begin w_wall = (r_seg_y[0] == '0);            w_ny = r_seg_y[0] - Y_W'(1); end
    endcase
  end

  // The tail vacates on a plain move, so it only counts as an obstacle when the snake grows.
  assign w_eat = (w_nx == r_apple_x) && (w_ny == r_apple_y);
  assign w_lim = w_eat ? r_len : r_len - L_W'(1);

  always_comb begin
    w_self = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((L_W'(i) < w_lim) && (r_seg_x[i] == w_nx) && (r_seg_y[i] == w_ny)) w_self = 1'b1;
    end
  end

  assign w_coll      = w_wall || w_self;
  assign w_cand_bad  = ({1'b0, r_cand_x} >= (X_W + 1)'(GRID_W)) || ({1'b0, r_cand_y} >= (Y_W + 1)'(GRID_H));
  assign w_scan_done = (r_idx == r_len);
  assign w_scan_hit  = (r_seg_x[r_idx[I_W-1:0]] == r_cand_x) && (r_seg_y[r_idx[I_W-1:0]] == r_cand_y);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DEAD: if (start) w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_do_step && w_coll)     w_state_nxt = S_DEAD;
        else if (w_do_step && w_eat) w_state_nxt = S_PLACE;
      end
      S_PLACE: if (!w_cand_bad && w_scan_done) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        r_seg_x[i] <= (i < 3) ? X_W'(GRID_W / 2 - i) : '0;
        r_seg_y[i] <= Y_W'(GRID_H / 2);
      end
      r_len     <= L_W'(3);
      r_dir     <= 2'd0;
      r_apple_x <= X_W'(GRID_W - 2);
      r_apple_y <= Y_W'(GRID_H / 2);
      r_cand_x  <= '0;
      r_cand_y  <= '0;
      r_idx     <= '0;
      r_lfsr    <= 8'hA5;
      r_pend    <= 1'b0;
      r_eaten   <= 1'b0;
      r_coll    <= 1'b0;
    end else begin
      r_lfsr  <= {r_lfsr[6:0], w_fb};
      r_eaten <= 1'b0;
      r_coll  <= 1'b0;
      case (r_state)
        S_IDLE, S_DEAD: begin
          if (start) begin
            for (int i = 0; i < MAX_LEN; i++) begin
              r_seg_x[i] <= (i < 3) ? X_W'(GRID_W / 2 - i) : '0;
              r_seg_y[i] <= Y_W'(GRID_H / 2);
            end
            r_len  <= L_W'(3);
            r_dir  <= 2'd0;
            r_pend <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_do_step) begin
            r_pend <= 1'b0;
            r_dir  <= w_dir;
            if (w_coll) begin
              r_coll <= 1'b1;
            end else begin
              for (int i = 1; i < MAX_LEN; i++) begin
                r_seg_x[i] <= r_seg_x[i-1];
                r_seg_y[i] <= r_seg_y[i-1];
              end
              r_seg_x[0] <= w_nx;
              r_seg_y[0] <= w_ny;
              if (w_eat) begin
                r_eaten  <= 1'b1;
                if (r_len != L_W'(MAX_LEN)) r_len <= r_len + L_W'(1);
                r_cand_x <= r_lfsr[X_W-1:0];
                r_cand_y <= r_lfsr[4 +: Y_W];
                r_idx    <= '0;
              end
            end
          end
        end
        S_PLACE: begin
          if (step) r_pend <= 1'b1;
          if (w_cand_bad || (!w_scan_done && w_scan_hit)) begin
            r_cand_x <= r_lfsr[X_W-1:0];
            r_cand_y <= r_lfsr[4 +: Y_W];
            r_idx    <= '0;
          end else if (w_scan_done) begin
            r_apple_x <= r_cand_x;
            r_apple_y <= r_cand_y;
          end else begin
            r_idx <= r_idx + L_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign apple_eaten = r_eaten;
  assign collision   = r_coll;
  assign head_x      = r_seg_x[0];
  assign head_y      = r_seg_y[0];
  assign apple_x     = r_apple_x;
  assign apple_y     = r_apple_y;
  assign length      = r_len;
  assign alive       = (r_state == S_RUN) || (r_state == S_PLACE);
endmodule
